ghost_dir_arbiter: RTL and testbench

Shares the single free-running 2-bit random source among N ghost controllers. Each ghost raises a request at an intersection. The arbiter grants requests round-robin and draws random candidates until it finds a legal direction: not into a wall and not a reversal. It returns one direction per grant. It sits between the random generator and the ghost movement FSMs.

---
 rtl/pacman_pkg.sv | 28 ++
 rtl/ghost_dir_arbiter_rr_picker.sv | 27 ++
 rtl/ghost_dir_arbiter.sv | 134 +++++++++++++
 tb/tb_ghost_dir_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/pacman_pkg.sv
// Shared definitions for the ghost direction logic: headings, wall-mask bit
// order and the arbiter state encoding.
package pacman_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  // Wall mask nibble: bit index equals the direction code, 1 = blocked.
  localparam int WALL_UP_BIT    = 0;
  localparam int WALL_RIGHT_BIT = 1;
  localparam int WALL_DOWN_BIT  = 2;
  localparam int WALL_LEFT_BIT  = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAW     = 2'd1,
    FALLBACK = 2'd2,
    GRANT    = 2'd3
  } arb_state_t;

  // Opposite heading; flipping bit 1 maps up<->down and right<->left.
  function automatic logic [1:0] reverse_dir(input logic [1:0] d);
    return d ^ 2'b10;
  endfunction

endpackage

// File: rtl/ghost_dir_arbiter_rr_picker.sv
// Round-robin search: first set request bit at or after ptr, wrapping at N.
module rr_picker #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] idx,
  output logic          found
);

  // Scan offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      int pos;
      pos = int'(ptr) + k;
      if (pos >= N) pos = pos - N;
      if (req[pos]) begin
        idx   = PW'(pos);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ghost_dir_arbiter.sv
// Shares one random direction source among the ghosts: round-robin accept,
// random draws until a legal heading, deterministic fallback when draws run out.
//
// state    | meaning
// IDLE     | waiting for any request; accepts one and latches its cell data
// DRAW     | tests the current random value against walls and reversal
// FALLBACK | draws exhausted; picks a heading deterministically
// GRANT    | one-cycle grant pulse with the chosen heading
module ghost_dir_arbiter
  import pacman_pkg::*;
#(
  parameter int N_GHOSTS  = 4,
  parameter int MAX_TRIES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            rand_val,
  input  logic [N_GHOSTS-1:0]   req,
  input  logic [4*N_GHOSTS-1:0] walls,
  input  logic [2*N_GHOSTS-1:0] cur_dir,
  output logic [N_GHOSTS-1:0]   grant,
  output logic [1:0]            dir_out,
  output logic                  busy
);

  localparam int PW = $clog2(N_GHOSTS);
  localparam int TW = $clog2(MAX_TRIES + 1);

  arb_state_t    state, state_d;
  logic [PW-1:0] ptr;
  logic [PW-1:0] idx_q;
  logic [3:0]    walls_q;
  logic [1:0]    cur_q;
  logic [TW-1:0] try_q, try_d;
  logic [1:0]    dir_q, dir_d;

  logic [PW-1:0] pick_idx;
  logic          pick_found;
  logic          accept;
  logic [1:0]    rev;
  logic          legal;
  logic [1:0]    fb_dir;

  rr_picker #(.N(N_GHOSTS), .PW(PW)) u_picker (
    .req   (req),
    .ptr   (ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign rev   = reverse_dir(cur_q);
  assign legal = !walls_q[rand_val] && (rand_val != rev);

  // Fallback heading: lowest open non-reverse, else open reverse, else stay put.
  always_comb begin
    fb_dir = cur_q;
    if (!walls_q[rev]) fb_dir = rev;
    for (int d = 3; d >= 0; d--) begin
      if (!walls_q[d] && (2'(d) != rev)) fb_dir = 2'(d);
    end
  end

  // Next-state logic and per-state datapath updates.
  always_comb begin
    state_d = state;
    try_d   = try_q;
    dir_d   = dir_q;
    accept  = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_found) begin
          accept  = 1'b1;
          try_d   = '0;
          state_d = DRAW;
        end
      end
      DRAW: begin
        if (legal) begin
          dir_d   = rand_val;
          state_d = GRANT;
        end else if (try_q == TW'(MAX_TRIES - 1)) begin
          state_d = FALLBACK;
        end else begin
          try_d = try_q + TW'(1);
        end
      end
      FALLBACK: begin
        dir_d   = fb_dir;
        state_d = GRANT;
      end
      GRANT: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode from the registered state so reset clears them at once.
  always_comb begin
    grant   = '0;
    dir_out = 2'd0;
    busy    = (state != IDLE);
    if (state == GRANT) begin
      grant[idx_q] = 1'b1;
      dir_out      = dir_q;
    end
  end

  // State, pointer and latched request data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      idx_q   <= '0;
      walls_q <= '0;
      cur_q   <= DIR_UP;
      try_q   <= '0;
      dir_q   <= DIR_UP;
    end else begin
      state <= state_d;
      try_q <= try_d;
      dir_q <= dir_d;
      if (accept) begin
        idx_q   <= pick_idx;
        walls_q <= walls[int'(pick_idx)*4 +: 4];
        cur_q   <= cur_dir[int'(pick_idx)*2 +: 2];
      end
      if (state == GRANT) begin
        ptr <= (idx_q == PW'(N_GHOSTS - 1)) ? '0 : idx_q + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ghost_dir_arbiter.sv
// Directed bench for ghost_dir_arbiter with an expected-grant scoreboard.
module tb_ghost_dir_arbiter;

  localparam int N  = 4;
  localparam int MT = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [1:0]     rand_val;
  logic [N-1:0]   req;
  logic [4*N-1:0] walls;
  logic [2*N-1:0] cur_dir;
  logic [N-1:0]   grant;
  logic [1:0]     dir_out;
  logic           busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int g;
    int dir;
    int lat;
  } exp_t;

  exp_t sb[$];

  ghost_dir_arbiter #(.N_GHOSTS(N), .MAX_TRIES(MT)) dut (
    .clk      (clk),
    .rst      (rst),
    .rand_val (rand_val),
    .req      (req),
    .walls    (walls),
    .cur_dir  (cur_dir),
    .grant    (grant),
    .dir_out  (dir_out),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic fail_timeout(input string tag);
    checks++;
    failures++;
    $error("FAIL %s observed=no_grant expected=grant", tag);
  endtask

  // Called at a negedge with grant nonzero; ref_cyc is the latency reference.
  task automatic check_grant(input int ref_cyc);
    exp_t e;
    chk("scoreboard_nonempty", 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("grant_onehot", 32'(grant), 32'd1 << e.g);
      chk("dir_out", 32'(dir_out), 32'(e.dir));
      chk("busy_in_grant", 32'(busy), 32'd1);
      if (e.lat > 0) chk("grant_latency", 32'(cyc - ref_cyc), 32'(e.lat));
    end
  endtask

  // Single-ghost request; rs holds the first two draws as {second, first}.
  task automatic serve(input int g, input logic [3:0] w, input logic [1:0] cd,
                       input logic [3:0] rs, input int edir, input int elat,
                       input bit scramble, input bit drop_early);
    int acc;
    bit got;
    exp_t e;
    @(negedge clk);
    walls[4*g +: 4]   = w;
    cur_dir[2*g +: 2] = cd;
    req[g]            = 1'b1;
    e = '{g, edir, elat};
    sb.push_back(e);
    @(posedge clk);
    #1;
    acc = cyc;
    chk("busy_after_accept", 32'(busy), 32'd1);
    rand_val = rs[1:0];
    if (scramble) begin
      walls[4*g +: 4]   = ~w;
      cur_dir[2*g +: 2] = cd ^ 2'b01;
    end
    if (drop_early) req[g] = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 12 && !got; k++) begin
      @(negedge clk);
      if (grant != '0) begin
        got = 1'b1;
        check_grant(acc);
        req[g] = 1'b0;
      end else begin
        @(posedge clk);
        #1;
        rand_val = (k == 0) ? rs[3:2] : 2'($urandom_range(0, 3));
      end
    end
    if (!got) begin
      fail_timeout("serve_grant_timeout");
      req[g] = 1'b0;
    end
    @(negedge clk);
    chk("grant_single_pulse", 32'(grant), 32'd0);
    chk("busy_after_grant", 32'(busy), 32'd0);
  endtask

  // Collect n grants in order; lat in each entry is the gap to the previous grant.
  task automatic collect(input int n, input bit clear_bits);
    int last;
    int seen;
    last = 0;
    seen = 0;
    for (int k = 0; k < 60 && seen < n; k++) begin
      @(negedge clk);
      if (grant != '0) begin
        check_grant(last);
        last = cyc;
        seen++;
        if (clear_bits) req = req & ~grant;
      end
    end
    if (seen < n) fail_timeout("collect_grant_timeout");
  endtask

  initial begin
    exp_t e;
    rst      = 1'b1;
    req      = '0;
    walls    = '0;
    cur_dir  = '0;
    rand_val = 2'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_grant", 32'(grant), 32'd0);
    chk("reset_dir_out", 32'(dir_out), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // Round robin with all four requests held, every draw legal.
    @(negedge clk);
    walls    = '0;
    cur_dir  = '0;
    rand_val = 2'd1;
    req      = 4'b1111;
    e = '{0, 1, 0}; sb.push_back(e);
    e = '{1, 1, 3}; sb.push_back(e);
    e = '{2, 1, 3}; sb.push_back(e);
    e = '{3, 1, 3}; sb.push_back(e);
    e = '{0, 1, 3}; sb.push_back(e);
    collect(5, 1'b0);
    req = '0;
    @(negedge clk);
    chk("rr_idle_busy", 32'(busy), 32'd0);

    // Open cell, first draw legal; inputs change after accept and must be ignored.
    serve(0, 4'b0000, 2'd1, {2'd0, 2'd0}, 0, 1, 1'b1, 1'b0);
    // First draw is the reverse, second draw accepted.
    serve(1, 4'b0000, 2'd0, {2'd3, 2'd2}, 3, 2, 1'b0, 1'b0);
    // Only reverse open: fallback picks reverse.
    serve(0, 4'b1011, 2'd0, {2'd1, 2'd0}, 2, 3, 1'b0, 1'b0);
    // Boxed in, request dropped right after accept: keeps heading, grant still pulses.
    serve(3, 4'b1111, 2'd3, {2'd0, 2'd2}, 3, 3, 1'b0, 1'b1);
    // Fallback prefers lowest open non-reverse heading.
    serve(2, 4'b1100, 2'd1, {2'd3, 2'd2}, 0, 3, 1'b0, 1'b0);
    // First draw hits a wall, second legal.
    serve(2, 4'b0001, 2'd2, {2'd1, 2'd0}, 1, 2, 1'b0, 1'b0);
    // Reverse then wall, fallback lands on left; leaves pointer at ghost 2.
    serve(1, 4'b0101, 2'd3, {2'd0, 2'd1}, 3, 3, 1'b0, 1'b0);

    // Reset mid-draw: ghost 2 boxed in so it sits in DRAW.
    @(negedge clk);
    walls[8 +: 4]   = 4'b1111;
    cur_dir[4 +: 2] = 2'd0;
    walls[0 +: 4]   = 4'b0000;
    cur_dir[0 +: 2] = 2'd0;
    rand_val        = 2'd1;
    req             = 4'b0100;
    @(posedge clk);
    @(negedge clk);
    chk("draw_busy_before_reset", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midreset_grant", 32'(grant), 32'd0);
    chk("midreset_busy", 32'(busy), 32'd0);
    // Pointer is back at 0, so ghost 0 precedes the still-pending ghost 2.
    req = 4'b0101;
    e = '{0, 1, 0}; sb.push_back(e);
    e = '{2, 0, 5}; sb.push_back(e);
    collect(2, 1'b1);
    req = '0;
    @(negedge clk);
    chk("final_busy", 32'(busy), 32'd0);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
